// File: rtl/ci_dispatch.sv
// ci_dispatch: initiator side of the custom-instruction (CI) bus.
// Takes one CPU request at a time, issues it to the responders, waits for
// ciDone, and returns the captured result to the CPU. The pipeline is
// stalled while an instruction is outstanding.
//
// Optional feature macro: CI_DISPATCH_TIMEOUT_EN
//   defined     -> watchdog aborts an instruction after timeoutCycles WAIT
//                  cycles without ciDone (response flagged with respTimeout)
//   not defined -> WAIT is left only on ciDone, respTimeout is tied low
//
// Handshakes: a request transfers on a rising edge where reqValid & reqReady
// are both high. reqReady depends on registered state only, and the CPU may
// hold reqValid high for as long as it wants. respValid is a one-cycle pulse
// with no back-pressure. respResult holds until the next response.
module ci_dispatch #(
    parameter logic [7:0]  idleCiN       = 8'hFF,
    parameter int unsigned timeoutCycles = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    input  logic [7:0]  reqCiN,
    input  logic [31:0] reqValueA,
    input  logic [31:0] reqValueB,
    output logic        reqReady,
    output logic        respValid,
    output logic [31:0] respResult,
    output logic        respTimeout,
    output logic        cpuStall,
    output logic [15:0] lastLatency,
    output logic        ciStart,
    output logic [7:0]  ciN,
    output logic [31:0] ciValueA,
    output logic [31:0] ciValueB,
    input  logic        ciDone,
    input  logic [31:0] ciResult,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_ci_n;
    logic [31:0] r_value_a;
    logic [31:0] r_value_b;
    logic [15:0] r_count;
    logic        r_resp_valid;
    logic        r_resp_timeout;
    logic [31:0] r_resp_result;
    logic [15:0] r_last_latency;

    logic        w_accept;
    logic        w_busy;
    logic        w_complete;
    logic        w_abort;
    logic [16:0] w_latency_sum;
    logic [15:0] w_latency;

    assign w_accept   = reqValid && (r_state == S_IDLE);
    assign w_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT);
    // ciDone/ciResult are only meaningful while an instruction is outstanding.
    assign w_complete = w_busy && ciDone;

`ifdef CI_DISPATCH_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(timeoutCycles);
    // A ciDone in the limit cycle wins over the abort.
    assign w_abort = (r_state == S_WAIT) && !ciDone && (r_count >= TIMEOUT_LIMIT);
`else
    assign w_abort = 1'b0;
`endif

    // r_count is 0 in ISSUE and equals k in the k-th WAIT cycle, so the
    // start-to-done latency (both cycles included) is r_count + 1.
    assign w_latency_sum = {1'b0, r_count} + 17'd1;
    assign w_latency     = w_latency_sum[16] ? 16'hFFFF : w_latency_sum[15:0];

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (reqValid) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = ciDone ? S_IDLE : S_WAIT;
            S_WAIT:  if (ciDone || w_abort) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Latch the accepted request; held until the next handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ci_n    <= 8'd0;
            r_value_a <= 32'd0;
            r_value_b <= 32'd0;
        end else if (w_accept) begin
            r_ci_n    <= reqCiN;
            r_value_a <= reqValueA;
            r_value_b <= reqValueB;
        end
    end

    // Latency/watchdog counter: cleared on acceptance, saturating count while busy.
    always_ff @(posedge clock) begin
        if (reset)                            r_count <= 16'd0;
        else if (w_accept)                    r_count <= 16'd0;
        else if (w_busy && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
    end

    // Completion registers: response pulse, result and latency capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_resp_valid   <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_resp_result  <= 32'd0;
            r_last_latency <= 16'd0;
        end else begin
            r_resp_valid   <= w_complete || w_abort;
            r_resp_timeout <= w_abort;
            if (w_complete) begin
                r_resp_result  <= ciResult;
                r_last_latency <= w_latency;
            end else if (w_abort) begin
                r_resp_result  <= 32'd0;
            end
        end
    end

    // Bus and CPU-side outputs decode registered state only.
    assign reqReady    = (r_state == S_IDLE);
    assign cpuStall    = (r_state != S_IDLE);
    assign ciStart     = (r_state == S_ISSUE);
    assign ciN         = w_busy ? r_ci_n    : idleCiN;
    assign ciValueA    = w_busy ? r_value_a : 32'd0;
    assign ciValueB    = w_busy ? r_value_b : 32'd0;
    assign respValid   = r_resp_valid;
    assign respTimeout = r_resp_timeout;
    assign respResult  = r_resp_result;
    assign lastLatency = r_last_latency;
    assign dbgState    = r_state;

endmodule

// File: tb/tb_ci_dispatch.sv
// Directed testbench for ci_dispatch (timeoutCycles = 8).
// Cycle k is the interval following the k-th rising edge after a request
// is first offered (cycle 0). Inputs are driven and outputs sampled 1 ns
// after each rising edge.
module tb_ci_dispatch;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid;
    logic [7:0]  reqCiN;
    logic [31:0] reqValueA;
    logic [31:0] reqValueB;
    logic        reqReady;
    logic        respValid;
    logic [31:0] respResult;
    logic        respTimeout;
    logic        cpuStall;
    logic [15:0] lastLatency;
    logic        ciStart;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic [1:0]  dbgState;

    int n_checks = 0;
    int n_errors = 0;

    ci_dispatch #(.idleCiN(8'hFF), .timeoutCycles(8)) dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqCiN(reqCiN), .reqValueA(reqValueA), .reqValueB(reqValueB),
        .reqReady(reqReady), .respValid(respValid), .respResult(respResult),
        .respTimeout(respTimeout), .cpuStall(cpuStall), .lastLatency(lastLatency),
        .ciStart(ciStart), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciDone(ciDone), .ciResult(ciResult), .dbgState(dbgState)
    );

    // Clock and global time limit.
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t required < 200000", $time);
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [7:0] id,
                             input logic [31:0] a, input logic [31:0] b);
        reqValid  = v;
        reqCiN    = id;
        reqValueA = a;
        reqValueB = b;
    endtask

    task automatic drive_done(input logic d, input logic [31:0] r);
        ciDone   = d;
        ciResult = r;
    endtask

    task automatic test_reset();
        drive_req(1'b0, 8'h00, 32'd0, 32'd0);
        drive_done(1'b0, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (reqReady !== 1'b1) begin n_errors++; $display("FAIL rst_reqReady got %b exp 1", reqReady); end
        n_checks++; if (cpuStall !== 1'b0) begin n_errors++; $display("FAIL rst_cpuStall got %b exp 0", cpuStall); end
        n_checks++; if (respValid !== 1'b0) begin n_errors++; $display("FAIL rst_respValid got %b exp 0", respValid); end
        n_checks++; if (respTimeout !== 1'b0) begin n_errors++; $display("FAIL rst_respTimeout got %b exp 0", respTimeout); end
        n_checks++; if (respResult !== 32'd0) begin n_errors++; $display("FAIL rst_respResult got %h exp 0", respResult); end
        n_checks++; if (lastLatency !== 16'd0) begin n_errors++; $display("FAIL rst_lastLatency got %0d exp 0", lastLatency); end
        n_checks++; if (ciStart !== 1'b0) begin n_errors++; $display("FAIL rst_ciStart got %b exp 0", ciStart); end
        n_checks++; if (ciN !== 8'hFF) begin n_errors++; $display("FAIL rst_ciN got %h exp ff", ciN); end
        n_checks++; if (ciValueA !== 32'd0) begin n_errors++; $display("FAIL rst_ciValueA got %h exp 0", ciValueA); end
        n_checks++; if (ciValueB !== 32'd0) begin n_errors++; $display("FAIL rst_ciValueB got %h exp 0", ciValueB); end
    endtask

    task automatic test_comb_responder();
        // cycle 0: offer request
        drive_req(1'b1, 8'h12, 32'hAAAA_0001, 32'hBBBB_0002);
        n_checks++; if (reqReady !== 1'b1) begin n_errors++; $display("FAIL comb_reqReady0 got %b exp 1", reqReady); end
        tick(); // cycle 1: ISSUE, responder answers in the same cycle
        drive_req(1'b0, 8'h00, 32'd0, 32'd0);
        n_checks++; if (ciStart !== 1'b1) begin n_errors++; $display("FAIL comb_ciStart1 got %b exp 1", ciStart); end
        n_checks++; if (cpuStall !== 1'b1) begin n_errors++; $display("FAIL comb_cpuStall1 got %b exp 1", cpuStall); end
        n_checks++; if (reqReady !== 1'b0) begin n_errors++; $display("FAIL comb_reqReady1 got %b exp 0", reqReady); end
        n_checks++; if (ciN !== 8'h12) begin n_errors++; $display("FAIL comb_ciN1 got %h exp 12", ciN); end
        n_checks++; if (ciValueA !== 32'hAAAA_0001) begin n_errors++; $display("FAIL comb_ciValueA1 got %h exp aaaa0001", ciValueA); end
        n_checks++; if (ciValueB !== 32'hBBBB_0002) begin n_errors++; $display("FAIL comb_ciValueB1 got %h exp bbbb0002", ciValueB); end
        drive_done(1'b1, 32'h0000_1234);
        tick(); // cycle 2: response
        drive_done(1'b0, 32'd0);
        n_checks++; if (respValid !== 1'b1) begin n_errors++; $display("FAIL comb_respValid2 got %b exp 1", respValid); end
        n_checks++; if (respResult !== 32'h0000_1234) begin n_errors++; $display("FAIL comb_respResult got %h exp 00001234", respResult); end
        n_checks++; if (respTimeout !== 1'b0) begin n_errors++; $display("FAIL comb_respTimeout got %b exp 0", respTimeout); end
        n_checks++; if (lastLatency !== 16'd1) begin n_errors++; $display("FAIL comb_lastLatency got %0d exp 1", lastLatency); end
        n_checks++; if (cpuStall !== 1'b0) begin n_errors++; $display("FAIL comb_cpuStall2 got %b exp 0", cpuStall); end
        n_checks++; if (ciStart !== 1'b0) begin n_errors++; $display("FAIL comb_ciStart2 got %b exp 0", ciStart); end
        n_checks++; if (ciN !== 8'hFF) begin n_errors++; $display("FAIL comb_ciN2 got %h exp ff", ciN); end
        tick(); // cycle 3: pulse over, result held
        n_checks++; if (respValid !== 1'b0) begin n_errors++; $display("FAIL comb_respValid3 got %b exp 0", respValid); end
        n_checks++; if (respResult !== 32'h0000_1234) begin n_errors++; $display("FAIL comb_respHold got %h exp 00001234", respResult); end
    endtask

    task automatic test_latency5();
        drive_req(1'b1, 8'h21, 32'h1111_2222, 32'h3333_4444);
        tick(); // cycle 1
        drive_req(1'b1, 8'h77, 32'hDEAD_0000, 32'hBEEF_0000); // ignored while busy
        for (int c = 1; c <= 5; c++) begin
            n_checks++; if (ciN !== 8'h21) begin n_errors++; $display("FAIL l5_ciN c%0d got %h exp 21", c, ciN); end
            n_checks++; if (ciValueA !== 32'h1111_2222) begin n_errors++; $display("FAIL l5_ciValueA c%0d got %h exp 11112222", c, ciValueA); end
            n_checks++; if (ciValueB !== 32'h3333_4444) begin n_errors++; $display("FAIL l5_ciValueB c%0d got %h exp 33334444", c, ciValueB); end
            n_checks++; if (cpuStall !== 1'b1) begin n_errors++; $display("FAIL l5_cpuStall c%0d got %b exp 1", c, cpuStall); end
            n_checks++; if (ciStart !== (c == 1)) begin n_errors++; $display("FAIL l5_ciStart c%0d got %b exp %b", c, ciStart, (c == 1)); end
            n_checks++; if (respValid !== 1'b0) begin n_errors++; $display("FAIL l5_respValid c%0d got %b exp 0", c, respValid); end
            if (c == 5) drive_done(1'b1, 32'h55AA_55AA);
            tick();
        end
        // cycle 6
        drive_done(1'b0, 32'd0);
        drive_req(1'b0, 8'h00, 32'd0, 32'd0);
        n_checks++; if (respValid !== 1'b1) begin n_errors++; $display("FAIL l5_respValid6 got %b exp 1", respValid); end
        n_checks++; if (respResult !== 32'h55AA_55AA) begin n_errors++; $display("FAIL l5_respResult got %h exp 55aa55aa", respResult); end
        n_checks++; if (lastLatency !== 16'd5) begin n_errors++; $display("FAIL l5_lastLatency got %0d exp 5", lastLatency); end
        n_checks++; if (cpuStall !== 1'b0) begin n_errors++; $display("FAIL l5_cpuStall6 got %b exp 0", cpuStall); end
        tick();
    endtask

    task automatic test_timeout();
        drive_req(1'b1, 8'h40, 32'h0000_00A0, 32'h0000_00B0);
        tick(); // cycle 1
        drive_req(1'b0, 8'h00, 32'd0, 32'd0);
`ifdef CI_DISPATCH_TIMEOUT_EN
        for (int c = 1; c <= 9; c++) begin
            n_checks++; if (respValid !== 1'b0) begin n_errors++; $display("FAIL to_respValid c%0d got %b exp 0", c, respValid); end
            n_checks++; if (cpuStall !== 1'b1) begin n_errors++; $display("FAIL to_cpuStall c%0d got %b exp 1", c, cpuStall); end
            tick();
        end
        // cycle 10
        n_checks++; if (respValid !== 1'b1) begin n_errors++; $display("FAIL to_respValid10 got %b exp 1", respValid); end
        n_checks++; if (respTimeout !== 1'b1) begin n_errors++; $display("FAIL to_respTimeout got %b exp 1", respTimeout); end
        n_checks++; if (respResult !== 32'd0) begin n_errors++; $display("FAIL to_respResult got %h exp 0", respResult); end
        n_checks++; if (ciN !== 8'hFF) begin n_errors++; $display("FAIL to_ciN got %h exp ff", ciN); end
        n_checks++; if (lastLatency !== 16'd5) begin n_errors++; $display("FAIL to_lastLatency got %0d exp 5", lastLatency); end
        n_checks++; if (cpuStall !== 1'b0) begin n_errors++; $display("FAIL to_cpuStall10 got %b exp 0", cpuStall); end
        tick();
`else
        // Without the watchdog the instruction stays outstanding indefinitely.
        for (int c = 1; c <= 12; c++) begin
            n_checks++; if (respValid !== 1'b0) begin n_errors++; $display("FAIL nto_respValid c%0d got %b exp 0", c, respValid); end
            n_checks++; if (cpuStall !== 1'b1) begin n_errors++; $display("FAIL nto_cpuStall c%0d got %b exp 1", c, cpuStall); end
            n_checks++; if (respTimeout !== 1'b0) begin n_errors++; $display("FAIL nto_respTimeout c%0d got %b exp 0", c, respTimeout); end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (cpuStall !== 1'b0) begin n_errors++; $display("FAIL nto_recover got %b exp 0", cpuStall); end
        // Restore a latency of 5 so later expectations are build-independent.
        drive_req(1'b1, 8'h41, 32'd1, 32'd2);
        tick();
        drive_req(1'b0, 8'h00, 32'd0, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) drive_done(1'b1, 32'h0000_0005);
            tick();
        end
        drive_done(1'b0, 32'd0);
        n_checks++; if (lastLatency !== 16'd5) begin n_errors++; $display("FAIL nto_lastLatency got %0d exp 5", lastLatency); end
        tick();
`endif
    endtask

    task automatic test_done_at_limit();
        drive_req(1'b1, 8'h50, 32'h0000_0050, 32'h0000_0051);
        tick(); // cycle 1
        drive_req(1'b0, 8'h00, 32'd0, 32'd0);
        for (int c = 1; c <= 8; c++) tick();
        // cycle 9: eighth WAIT cycle, the watchdog limit
        n_checks++; if (cpuStall !== 1'b1) begin n_errors++; $display("FAIL lim_cpuStall9 got %b exp 1", cpuStall); end
        n_checks++; if (respValid !== 1'b0) begin n_errors++; $display("FAIL lim_respValid9 got %b exp 0", respValid); end
        drive_done(1'b1, 32'hCAFE_F00D);
        tick(); // cycle 10
        drive_done(1'b0, 32'd0);
        n_checks++; if (respValid !== 1'b1) begin n_errors++; $display("FAIL lim_respValid10 got %b exp 1", respValid); end
        n_checks++; if (respTimeout !== 1'b0) begin n_errors++; $display("FAIL lim_respTimeout got %b exp 0", respTimeout); end
        n_checks++; if (respResult !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL lim_respResult got %h exp cafef00d", respResult); end
        n_checks++; if (lastLatency !== 16'd9) begin n_errors++; $display("FAIL lim_lastLatency got %0d exp 9", lastLatency); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        drive_req(1'b1, 8'h60, 32'h0000_0060, 32'h0000_0061);
        tick(); // cycle 1
        drive_req(1'b0, 8'h00, 32'd0, 32'd0);
        tick(); // cycle 2
        tick(); // cycle 3, WAIT
        n_checks++; if (ciN !== 8'h60) begin n_errors++; $display("FAIL rw_ciN3 got %h exp 60", ciN); end
        reset = 1'b1;
        tick(); // cycle 4
        reset = 1'b0;
        n_checks++; if (cpuStall !== 1'b0) begin n_errors++; $display("FAIL rw_cpuStall got %b exp 0", cpuStall); end
        n_checks++; if (ciN !== 8'hFF) begin n_errors++; $display("FAIL rw_ciN got %h exp ff", ciN); end
        n_checks++; if (reqReady !== 1'b1) begin n_errors++; $display("FAIL rw_reqReady got %b exp 1", reqReady); end
        n_checks++; if (respValid !== 1'b0) begin n_errors++; $display("FAIL rw_respValid4 got %b exp 0", respValid); end
        n_checks++; if (lastLatency !== 16'd0) begin n_errors++; $display("FAIL rw_lastLatency got %0d exp 0", lastLatency); end
        n_checks++; if (respResult !== 32'd0) begin n_errors++; $display("FAIL rw_respResult got %h exp 0", respResult); end
        drive_done(1'b1, 32'h9999_9999); // late answer, must be ignored
        tick(); // cycle 5
        drive_done(1'b0, 32'd0);
        n_checks++; if (respValid !== 1'b0) begin n_errors++; $display("FAIL rw_respValid5 got %b exp 0", respValid); end
        n_checks++; if (respResult !== 32'd0) begin n_errors++; $display("FAIL rw_lateResult got %h exp 0", respResult); end
        n_checks++; if (cpuStall !== 1'b0) begin n_errors++; $display("FAIL rw_cpuStall5 got %b exp 0", cpuStall); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_req(1'b1, 8'h31, 32'h0000_A001, 32'h0000_B001);
        tick(); // cycle 1: first ISSUE
        n_checks++; if (ciStart !== 1'b1) begin n_errors++; $display("FAIL b2b_ciStart1 got %b exp 1", ciStart); end
        n_checks++; if (ciN !== 8'h31) begin n_errors++; $display("FAIL b2b_ciN1 got %h exp 31", ciN); end
        drive_req(1'b1, 8'h32, 32'h0000_A002, 32'h0000_B002);
        drive_done(1'b1, 32'h0000_0111);
        tick(); // cycle 2: IDLE, response 1, second request accepted
        drive_done(1'b0, 32'd0);
        n_checks++; if (ciStart !== 1'b0) begin n_errors++; $display("FAIL b2b_ciStart2 got %b exp 0", ciStart); end
        n_checks++; if (respValid !== 1'b1) begin n_errors++; $display("FAIL b2b_respValid2 got %b exp 1", respValid); end
        n_checks++; if (respResult !== 32'h0000_0111) begin n_errors++; $display("FAIL b2b_result1 got %h exp 00000111", respResult); end
        n_checks++; if (reqReady !== 1'b1) begin n_errors++; $display("FAIL b2b_reqReady2 got %b exp 1", reqReady); end
        tick(); // cycle 3: second ISSUE
        drive_req(1'b0, 8'h00, 32'd0, 32'd0);
        n_checks++; if (ciStart !== 1'b1) begin n_errors++; $display("FAIL b2b_ciStart3 got %b exp 1", ciStart); end
        n_checks++; if (ciN !== 8'h32) begin n_errors++; $display("FAIL b2b_ciN3 got %h exp 32", ciN); end
        n_checks++; if (ciValueA !== 32'h0000_A002) begin n_errors++; $display("FAIL b2b_ciValueA3 got %h exp 0000a002", ciValueA); end
        n_checks++; if (ciValueB !== 32'h0000_B002) begin n_errors++; $display("FAIL b2b_ciValueB3 got %h exp 0000b002", ciValueB); end
        drive_done(1'b1, 32'h0000_0222);
        tick(); // cycle 4: response 2
        drive_done(1'b0, 32'd0);
        n_checks++; if (respValid !== 1'b1) begin n_errors++; $display("FAIL b2b_respValid4 got %b exp 1", respValid); end
        n_checks++; if (respResult !== 32'h0000_0222) begin n_errors++; $display("FAIL b2b_result2 got %h exp 00000222", respResult); end
        n_checks++; if (lastLatency !== 16'd1) begin n_errors++; $display("FAIL b2b_lastLatency got %0d exp 1", lastLatency); end
        tick(); // cycle 5
        n_checks++; if (ciStart !== 1'b0) begin n_errors++; $display("FAIL b2b_ciStart5 got %b exp 0", ciStart); end
        n_checks++; if (cpuStall !== 1'b0) begin n_errors++; $display("FAIL b2b_cpuStall5 got %b exp 0", cpuStall); end
    endtask

    initial begin
        reset = 1'b1;
        drive_req(1'b0, 8'h00, 32'd0, 32'd0);
        drive_done(1'b0, 32'd0);
        test_reset();
        test_comb_responder();
        test_latency5();
        test_timeout();
        test_done_at_limit();
        test_reset_in_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ci_dispatch.md
# ci_dispatch

Initiator side of the custom-instruction (CI) interface. Accepts one CI request at a time from the CPU execute stage and drives `start`/`ciN`/`valueA`/`valueB` to the CI bus. It waits for a responder such as the profiling counter block to raise `done`, captures `result`, and returns it to the CPU. It also stalls the pipeline while the instruction is outstanding and aborts it with a watchdog if no responder answers.

## Interface
- `idleCiN`, default 8'hFF: value driven on `ciN` when no instruction is outstanding; no responder may use this ID.
- `timeoutCycles`, default 1024: number of WAIT cycles without `ciDone` before abort; legal range 1..65535.
- `clock` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `reqValid` input 1: CPU presents a CI request.
- `reqCiN` input 8: custom instruction ID.
- `reqValueA` input 32: operand A.
- `reqValueB` input 32: operand B.
- `reqReady` output 1: high only in IDLE; a request transfers when `reqValid & reqReady`.
- `respValid` output 1: one-cycle pulse; response fields are valid.
- `respResult` output 32: captured `ciResult`, or 0 on timeout.
- `respTimeout` output 1: qualifies `respValid`; instruction was aborted.
- `cpuStall` output 1: high whenever state is not IDLE.
- `lastLatency` output 16: cycles from the `ciStart` cycle to the `ciDone` cycle, inclusive of both; held until the next completion.
- `ciStart` output 1: one-cycle start pulse to the responders.
- `ciN` output 8: instruction ID on the CI bus.
- `ciValueA` output 32: operand A on the CI bus.
- `ciValueB` output 32: operand B on the CI bus.
- `ciDone` input 1: responder completion.
- `ciResult` input 32: responder result, sampled only when `ciDone` is high.

## Operation
- States:
  - IDLE: `reqReady`=1; on handshake, latch ID and operands and go to ISSUE.
  - ISSUE: `ciStart`=1 for exactly this cycle with the latched ID and operands.
    - If `ciDone`=1 in this cycle (combinational responder), capture the result, set `lastLatency`=1 and go to IDLE.
    - Otherwise go to WAIT.
  - WAIT: `ciStart`=0.
    - Each cycle: if `ciDone`=1, capture the result, set `lastLatency` = counter+1 and go to IDLE.
    - Otherwise, once the watchdog reaches `timeoutCycles`, abort and go to IDLE.
- `ciN`, `ciValueA` and `ciValueB` are held stable from ISSUE through the cycle `ciDone` is sampled (or the abort cycle).
- In IDLE: `ciN`=`idleCiN`, `ciValueA`=0, `ciValueB`=0.
- `ciDone` and `ciResult` are ignored while in IDLE.
- Completion registers:
  - `respValid`=1 in the cycle after the capture or abort; this coincides with the first IDLE cycle.
  - `respTimeout` and `respResult` are registered on the same edge.
  - `respResult` holds its value until the next response.
- Watchdog counter: 16 bits, cleared in ISSUE, increments in WAIT, saturates and never wraps.
  - `ciDone` arriving in the same cycle the limit is reached takes priority: normal completion, no timeout.
- `lastLatency` saturates at 16'hFFFF and is not updated on timeout.
- A request offered in the same cycle `respValid` is high is accepted, since the block is already in IDLE.
- Reset mid-operation: return to IDLE and force every output to its reset value. Any outstanding instruction is dropped with no response.
- Reset values:
  - `reqReady`=1, `cpuStall`=0.
  - `respValid`=0, `respTimeout`=0, `respResult`=0, `lastLatency`=0.
  - `ciStart`=0, `ciN`=`idleCiN`, `ciValueA`=0, `ciValueB`=0.

## Timing
- Request accepted at edge N. `ciStart` is high during cycle N+1.
- Responder latency L (`ciDone` high L-1 cycles after the `ciStart` cycle, L≥1): `respValid` is high in cycle N+1+L.
- `cpuStall` is high from cycle N+1 through cycle N+L.
- Back-to-back minimum period: L+1 cycles per instruction.
- Timeout: `respValid` with `respTimeout`=1 at cycle N+2+`timeoutCycles`.
- `cpuStall`, `reqReady` and `ciStart` are decoded from registered state only, with no combinational path from `ciDone`.

## Configuration
- `CI_DISPATCH_TIMEOUT_EN` defined: watchdog counter present; behaviour as above.
- Not defined:
  - WAIT is left only on `ciDone`.
  - `respTimeout` is tied to 0.
  - `timeoutCycles` is ignored.
  - The counter is still built to produce `lastLatency`.

## Test plan
- Combinational responder (done in the start cycle, result 32'h0000_1234):
  - request accepted at cycle 0;
  - `ciStart` at cycle 1, `respValid` at cycle 2;
  - `respResult`=32'h1234, `lastLatency`=1, `cpuStall` high only in cycle 1.
- 5-cycle responder:
  - `ciN`/`ciValueA`/`ciValueB` held stable cycles 1..5;
  - `respValid` at cycle 6, `lastLatency`=5.
- No responder, `timeoutCycles`=8:
  - `respValid`=1, `respTimeout`=1, `respResult`=0 at cycle 10;
  - `ciN` returns to 8'hFF;
  - `lastLatency` unchanged.
- `ciDone` asserted in the same cycle the watchdog reaches its limit: normal completion, `respTimeout`=0.
- `reset` pulsed in WAIT:
  - next cycle IDLE, `ciN`=8'hFF, `cpuStall`=0;
  - no `respValid`;
  - a late `ciDone` is ignored.
- Back-to-back requests held valid with a 1-cycle responder: second `ciStart` two cycles after the first, with correct operands.
